// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: round-robin sequencer for one shared shift-register datapath.
// Each granted operation is one load cycle, NBITS shift cycles and a
// one-cycle done pulse. All outputs are decoded from registered state only.
module shift_arb_ctrl #(
    parameter int NBITS = 4,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       sel,
    output logic       Ld,
    output logic       Sh,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state, state_n;
    logic [1:0]         grant_q, grant_n;
    logic [CNT_W-1:0]   cnt;
    logic               last;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

    // Single requester wins outright; on a tie the one that did not go last wins.
    function automatic logic [1:0] arb(input logic [1:0] r, input logic lst);
        if (r == 2'b11) return lst ? 2'b01 : 2'b10;
        return r;
    endfunction

    // Next-state and next-grant decode; req only matters in IDLE and DONE.
    always_comb begin
        state_n = state;
        grant_n = grant_q;
        case (state)
            IDLE: begin
                grant_n = 2'b00;
                if (req != 2'b00) begin
                    grant_n = arb(req, last);
                    state_n = LOAD;
                end
            end
            LOAD:  state_n = SHIFT;
            SHIFT: if (cnt == CNT_LAST) state_n = DONE;
            DONE: begin
                // Pointer update (last <= sel) is applied here ahead of the register.
                if (req != 2'b00) begin
                    grant_n = arb(req, grant_q[1]);
                    state_n = LOAD;
                end else begin
                    grant_n = 2'b00;
                    state_n = IDLE;
                end
            end
            default: begin
                grant_n = 2'b00;
                state_n = IDLE;
            end
        endcase
    end

    // State, grant, shift counter and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            cnt     <= '0;
            last    <= 1'b1;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            case (state)
                LOAD:  cnt <= '0;
                // Wrap instead of incrementing past the final shift.
                SHIFT: cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                DONE:  last <= grant_q[1];
                default: ;
            endcase
        end
    end

    // Moore output decode.
    always_comb begin
        grant = grant_q;
        sel   = grant_q[1];
        Ld    = (state == LOAD);
        Sh    = (state == SHIFT);
        busy  = (state != IDLE);
        done  = (state == DONE);
    end

endmodule
